// File: rtl/flow_sequencer.sv
// Program-flow sequencer: owns the PC, runs the fetch handshake, applies
// resolved flow ops from decode, and handles trap entry/return.
module flow_sequencer #(
   parameter int unsigned        ADDR_W      = 20,
   parameter logic [ADDR_W-1:0]  RESET_PC    = 20'h00000,
   parameter logic [ADDR_W-1:0]  TRAP_VECTOR = 20'h00010
) (
   input  logic              clock,
   input  logic              reset,
   output logic              fetch_req,
   output logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_ack,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [2:0]        br_op,
   input  logic [ADDR_W-1:0] rel_addr,
   input  logic [3:0]        status_in,
   input  logic              alu_trap,
   output logic [ADDR_W-1:0] pc,
   output logic              trap_mode,
   output logic [ADDR_W-1:0] epc,
   output logic [3:0]        saved_status,
   output logic              restore_status,
   output logic              redirect,
   output logic              halted
);

   localparam logic [2:0] OpNop   = 3'd0;
   localparam logic [2:0] OpJmp   = 3'd1;
   localparam logic [2:0] OpJmpz  = 3'd2;
   localparam logic [2:0] OpJmps  = 3'd3;
   localparam logic [2:0] OpJmpzs = 3'd4;
   localparam logic [2:0] OpTrap  = 3'd5;
   localparam logic [2:0] OpRtt   = 3'd6;

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   state_e            state;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jmp_tgt;
   logic              jmp_taken;
   logic              trap_req;
   logic              rtt_req;

   assign fetch_addr = pc;

   // Next-PC candidates and branch condition decode (all arithmetic wraps)
   always_comb begin
      pc_inc    = pc + 1'b1;
      jmp_tgt   = pc + rel_addr;
      jmp_taken = 1'b0;
      unique case (br_op)
         OpJmp:   jmp_taken = 1'b1;
         OpJmpz:  jmp_taken = status_in[0];
         OpJmps:  jmp_taken = status_in[1];
         OpJmpzs: jmp_taken = status_in[0] | status_in[1];
         default: jmp_taken = 1'b0;
      endcase
      // alu_trap overrides whatever op decode resolved
      trap_req = alu_trap || (br_op == OpTrap);
      rtt_req  = !alu_trap && (br_op == OpRtt) && trap_mode;
   end

   // Sequencer FSM with registered handshake, PC and trap-shadow state
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= StFetch;
         pc             <= RESET_PC;
         fetch_req      <= 1'b0;
         br_ready       <= 1'b0;
         trap_mode      <= 1'b0;
         epc            <= '0;
         saved_status   <= '0;
         restore_status <= 1'b0;
         redirect       <= 1'b0;
         halted         <= 1'b0;
      end else begin
         restore_status <= 1'b0;
         redirect       <= 1'b0;
         unique case (state)
            StFetch: begin
               if (!fetch_req) begin
                  // First cycle out of reset: raise the request, ignore any ack
                  fetch_req <= 1'b1;
               end else if (fetch_ack) begin
                  fetch_req <= 1'b0;
                  br_ready  <= 1'b1;
                  state     <= StExec;
               end
            end
            StExec: begin
               if (br_valid) begin
                  br_ready <= 1'b0;
                  if (trap_req && trap_mode) begin
                     // Double trap: freeze pc/epc/saved_status and stop
                     halted <= 1'b1;
                     state  <= StHalt;
                  end else begin
                     fetch_req <= 1'b1;
                     state     <= StFetch;
                     if (trap_req) begin
                        epc          <= pc_inc;
                        saved_status <= status_in;
                        trap_mode    <= 1'b1;
                        pc           <= TRAP_VECTOR;
                        redirect     <= 1'b1;
                     end else if (rtt_req) begin
                        pc             <= epc;
                        trap_mode      <= 1'b0;
                        restore_status <= 1'b1;
                        redirect       <= 1'b1;
                     end else if (jmp_taken) begin
                        pc       <= jmp_tgt;
                        redirect <= (jmp_tgt != pc_inc);
                     end else begin
                        pc <= pc_inc;
                     end
                  end
               end
            end
            StHalt: begin
               fetch_req <= 1'b0;
               br_ready  <= 1'b0;
            end
            default: state <= StHalt;
         endcase
      end
   end

endmodule

// File: tb/tb_flow_sequencer.sv
// Directed bench for flow_sequencer with hand-computed expected values.
module tb_flow_sequencer;

   localparam int unsigned ADDR_W = 20;
   localparam logic [2:0] OpNop   = 3'd0;
   localparam logic [2:0] OpJmp   = 3'd1;
   localparam logic [2:0] OpJmpz  = 3'd2;
   localparam logic [2:0] OpJmps  = 3'd3;
   localparam logic [2:0] OpJmpzs = 3'd4;
   localparam logic [2:0] OpTrap  = 3'd5;
   localparam logic [2:0] OpRtt   = 3'd6;
   localparam logic [2:0] OpAlu   = 3'd7;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_ack = 1'b0;
   logic              br_valid = 1'b0;
   logic              br_ready;
   logic [2:0]        br_op = 3'd0;
   logic [ADDR_W-1:0] rel_addr = '0;
   logic [3:0]        status_in = 4'd0;
   logic              alu_trap = 1'b0;
   logic [ADDR_W-1:0] pc;
   logic              trap_mode;
   logic [ADDR_W-1:0] epc;
   logic [3:0]        saved_status;
   logic              restore_status;
   logic              redirect;
   logic              halted;

   int errors = 0;
   int checks = 0;

   flow_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .fetch_req      (fetch_req),
      .fetch_addr     (fetch_addr),
      .fetch_ack      (fetch_ack),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_op          (br_op),
      .rel_addr       (rel_addr),
      .status_in      (status_in),
      .alu_trap       (alu_trap),
      .pc             (pc),
      .trap_mode      (trap_mode),
      .epc            (epc),
      .saved_status   (saved_status),
      .restore_status (restore_status),
      .redirect       (redirect),
      .halted         (halted)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Wait (bounded) for a fetch request, check its address, then ack it
   task automatic do_fetch(input logic [ADDR_W-1:0] exp_addr);
      int n = 0;
      while (!fetch_req && n < 20) begin
         tick();
         n++;
      end
      check_eq("fetch_req_seen", 32'(fetch_req), 32'd1);
      check_eq("fetch_addr", 32'(fetch_addr), 32'(exp_addr));
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
   endtask

   // Wait (bounded) for br_ready, present one resolved op for one edge
   task automatic do_exec(input logic [2:0] op, input logic [ADDR_W-1:0] rel,
                          input logic [3:0] st, input logic trap);
      int n = 0;
      while (!br_ready && n < 20) begin
         tick();
         n++;
      end
      check_eq("br_ready_seen", 32'(br_ready), 32'd1);
      br_op     = op;
      rel_addr  = rel;
      status_in = st;
      alu_trap  = trap;
      br_valid  = 1'b1;
      tick();
      br_valid  = 1'b0;
      alu_trap  = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check_eq("rst_pc", 32'(pc), 32'h0);
      check_eq("rst_fetch_req", 32'(fetch_req), 32'd0);
      check_eq("rst_br_ready", 32'(br_ready), 32'd0);
      check_eq("rst_trap_mode", 32'(trap_mode), 32'd0);
      check_eq("rst_epc", 32'(epc), 32'h0);
      check_eq("rst_saved_status", 32'(saved_status), 32'h0);
      check_eq("rst_redirect", 32'(redirect), 32'd0);
      check_eq("rst_restore", 32'(restore_status), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);

      // Release reset with a stray ack: must be ignored, request rises
      reset     = 1'b1;
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      check_eq("first_fetch_req", 32'(fetch_req), 32'd1);
      check_eq("stray_ack_br_ready", 32'(br_ready), 32'd0);

      // NOP stream 0..4
      for (int i = 0; i < 5; i++) begin
         do_fetch(20'(i));
         do_exec(OpNop, 20'h0, 4'h0, 1'b0);
         check_eq("nop_redirect", 32'(redirect), 32'd0);
         check_eq("nop_pc", 32'(pc), 32'(i + 1));
      end

      // JMPZ backward taken from 5 -> 3
      do_fetch(20'h00005);
      do_exec(OpJmpz, 20'hFFFFE, 4'b0001, 1'b0);
      check_eq("jmpz_taken_pc", 32'(pc), 32'h3);
      check_eq("jmpz_taken_redirect", 32'(redirect), 32'd1);
      tick();
      check_eq("redirect_one_cycle", 32'(redirect), 32'd0);

      // JMPZ untaken from 3 -> 4
      do_fetch(20'h00003);
      do_exec(OpJmpz, 20'hFFFFE, 4'b0000, 1'b0);
      check_eq("jmpz_untaken_pc", 32'(pc), 32'h4);
      check_eq("jmpz_untaken_redirect", 32'(redirect), 32'd0);

      // JMPZS with S only -> taken
      do_fetch(20'h00004);
      do_exec(OpJmpzs, 20'h00010, 4'b0010, 1'b0);
      check_eq("jmpzs_pc", 32'(pc), 32'h14);
      check_eq("jmpzs_redirect", 32'(redirect), 32'd1);

      // JMPS with S=0 (Z=1) -> untaken
      do_fetch(20'h00014);
      do_exec(OpJmps, 20'h00010, 4'b0001, 1'b0);
      check_eq("jmps_untaken_pc", 32'(pc), 32'h15);
      check_eq("jmps_untaken_redirect", 32'(redirect), 32'd0);

      // JMP to top of address space, then wrap forward
      do_fetch(20'h00015);
      do_exec(OpJmp, 20'hFFFEA, 4'b0000, 1'b0);
      check_eq("jmp_to_top_pc", 32'(pc), 32'hFFFFF);
      do_fetch(20'hFFFFF);
      do_exec(OpJmp, 20'h00002, 4'b0000, 1'b0);
      check_eq("jmp_wrap_pc", 32'(pc), 32'h1);
      check_eq("jmp_wrap_redirect", 32'(redirect), 32'd1);

      // Move to 0x40, then alu_trap overriding JMP
      do_fetch(20'h00001);
      do_exec(OpJmp, 20'h0003F, 4'b0000, 1'b0);
      do_fetch(20'h00040);
      do_exec(OpJmp, 20'h00005, 4'b1010, 1'b1);
      check_eq("trap_pc", 32'(pc), 32'h10);
      check_eq("trap_epc", 32'(epc), 32'h41);
      check_eq("trap_saved_status", 32'(saved_status), 32'hA);
      check_eq("trap_mode_set", 32'(trap_mode), 32'd1);
      check_eq("trap_redirect", 32'(redirect), 32'd1);

      // Stalled fetch with br_valid asserted: all stable, nothing accepted
      br_valid = 1'b1;
      br_op    = OpJmp;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("stall_fetch_req", 32'(fetch_req), 32'd1);
         check_eq("stall_fetch_addr", 32'(fetch_addr), 32'h10);
         check_eq("stall_br_ready", 32'(br_ready), 32'd0);
      end
      br_valid = 1'b0;
      do_fetch(20'h00010);
      do_exec(OpAlu, 20'h00100, 4'b0000, 1'b0);
      check_eq("alu_pc", 32'(pc), 32'h11);

      // RTT in trap mode returns to epc
      do_fetch(20'h00011);
      do_exec(OpRtt, 20'h0, 4'b0000, 1'b0);
      check_eq("rtt_pc", 32'(pc), 32'h41);
      check_eq("rtt_trap_mode", 32'(trap_mode), 32'd0);
      check_eq("rtt_restore", 32'(restore_status), 32'd1);
      check_eq("rtt_redirect", 32'(redirect), 32'd1);
      tick();
      check_eq("restore_one_cycle", 32'(restore_status), 32'd0);

      // RTT outside trap mode behaves as NOP
      do_fetch(20'h00041);
      do_exec(OpRtt, 20'h0, 4'b0000, 1'b0);
      check_eq("rtt_nop_pc", 32'(pc), 32'h42);
      check_eq("rtt_nop_restore", 32'(restore_status), 32'd0);
      check_eq("rtt_nop_redirect", 32'(redirect), 32'd0);

      // TRAP op, then double trap -> halt
      do_fetch(20'h00042);
      do_exec(OpTrap, 20'h0, 4'b0101, 1'b0);
      check_eq("trap2_epc", 32'(epc), 32'h43);
      do_fetch(20'h00010);
      do_exec(OpTrap, 20'h0, 4'b1111, 1'b0);
      check_eq("halt_halted", 32'(halted), 32'd1);
      check_eq("halt_pc_hold", 32'(pc), 32'h10);
      check_eq("halt_epc_hold", 32'(epc), 32'h43);
      check_eq("halt_status_hold", 32'(saved_status), 32'h5);
      fetch_ack = 1'b1;
      br_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("halt_fetch_req", 32'(fetch_req), 32'd0);
         check_eq("halt_br_ready", 32'(br_ready), 32'd0);
         check_eq("halt_sticky", 32'(halted), 32'd1);
      end
      fetch_ack = 1'b0;
      br_valid  = 1'b0;

      // One-edge reset clears halt and resumes fetching at 0
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_eq("rerst_pc", 32'(pc), 32'h0);
      check_eq("rerst_halted", 32'(halted), 32'd0);
      check_eq("rerst_trap_mode", 32'(trap_mode), 32'd0);
      check_eq("rerst_epc", 32'(epc), 32'h0);
      do_fetch(20'h00000);
      do_exec(OpNop, 20'h0, 4'b0000, 1'b0);
      check_eq("resume_pc", 32'(pc), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
